// File: rtl/coriolis_stream_src.sv
// coriolis_stream_src: streams nitems IEEE-754 singles from RAM to a kernel node as 34-bit FloPoCo words.
// Latency: first ovalid 3 cycles after an accepted start; 1 item/cycle sustained with oready high.
// Backpressure: 2-entry output buffer; RAM reads are throttled so the buffer never overflows.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, nitems       job request (sampled in IDLE only) and item count 0..2^ADDRW
//   busy, done          job in progress (cycle after start through DONE), one-cycle completion pulse
//   mem_rd, mem_addr    RAM read enable/address; mem_rdata returns one cycle after mem_rd
//   ovalid, out1, oready  output stream {exc[1:0], word[31:0]}, transfer on ovalid & oready
module coriolis_stream_src #(
   parameter int DATAW   = 32,
   parameter int STREAMW = 34,
   parameter int ADDRW   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDRW:0]     nitems,
   output logic               busy,
   output logic               done,
   output logic               mem_rd,
   output logic [ADDRW-1:0]   mem_addr,
   input  logic [DATAW-1:0]   mem_rdata,
   output logic               ovalid,
   output logic [STREAMW-1:0] out1,
   input  logic               oready
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ADDRW:0] CNT_ONE = {{ADDRW{1'b0}}, 1'b1};

   state_t             state, state_nx;
   logic [ADDRW:0]     n_lat;
   logic [ADDRW:0]     rd_cnt;
   logic [ADDRW:0]     tx_cnt;
   logic [ADDRW:0]     tx_cnt_nx;
   logic               inflight;

   logic [STREAMW-1:0] fifo_mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         occ;

   logic               push;
   logic               pop;
   logic [2:0]         need;
   logic [2:0]         room;

   logic [7:0]         rd_e;
   logic [22:0]        rd_f;
   logic [STREAMW-1:0] rd_conv;

   assign pop       = ovalid & oready;
   assign push      = inflight;
   assign tx_cnt_nx = tx_cnt + {{ADDRW{1'b0}}, pop};

   // Issue only if the item it returns is guaranteed a slot: entries held plus the
   // one still in flight, minus the one leaving now, must stay below 2.
   assign need   = {1'b0, occ} + {2'b00, inflight};
   assign room   = 3'd2 + {2'b00, pop};
   assign mem_rd = (state == S_RUN) && (rd_cnt < n_lat) && (need < room);

   assign mem_addr = rd_cnt[ADDRW-1:0];
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign ovalid   = (occ != 2'd0);
   assign out1     = fifo_mem[rd_ptr];

   // IEEE single -> FloPoCo: denormals flush to signed zero, inf/NaN tagged by exc.
   always_comb begin
      rd_e    = mem_rdata[30:23];
      rd_f    = mem_rdata[22:0];
      rd_conv = {2'b01, mem_rdata};
      if (rd_e == 8'h00) begin
         rd_conv = {2'b00, mem_rdata[31], 31'd0};
      end else if (rd_e == 8'hff) begin
         rd_conv = (rd_f == 23'd0) ? {2'b10, mem_rdata} : {2'b11, mem_rdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (nitems == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // Leave as the final transfer happens so DONE lands the following cycle.
            if (tx_cnt_nx == n_lat) begin
               state_nx = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_lat    <= '0;
         rd_cnt   <= '0;
         tx_cnt   <= '0;
         inflight <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         occ      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         // A response for a read issued just before reset is dropped because
         // inflight is cleared above.
         inflight <= mem_rd;
         if (state == S_IDLE && start) begin
            n_lat  <= nitems;
            rd_cnt <= '0;
            tx_cnt <= '0;
         end else begin
            if (mem_rd) begin
               rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (pop) begin
               tx_cnt <= tx_cnt_nx;
            end
         end
         if (push) begin
            fifo_mem[wr_ptr] <= rd_conv;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule
